// File: rtl/audio_pkg.sv
// Shared types and default widths for the audio unpacker slice.
package audio_pkg;

  localparam int AUDIO_WORD_W   = 32;
  localparam int AUDIO_SAMPLE_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } audio_state_e;

endpackage

// File: rtl/audio_word_buf.sv
// Two-slot word buffer: CUR is the word being played, NXT is the prefetch slot.
// A load goes to CUR when CUR is free (or being popped with NXT empty), else to NXT.
module audio_word_buf
  import audio_pkg::*;
#(
  parameter int WORD_W = AUDIO_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              pop,
  input  logic [WORD_W-1:0] word_data,
  output logic [WORD_W-1:0] cur_word,
  output logic [WORD_W-1:0] nxt_word,
  output logic              cur_full,
  output logic              nxt_empty
);

  logic nxt_full;

  assign nxt_empty = ~nxt_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_word <= '0;
      nxt_word <= '0;
      cur_full <= 1'b0;
      nxt_full <= 1'b0;
    end else if (pop) begin
      // NXT promotes into CUR; a load cannot coincide because ready is low when NXT is full.
      if (nxt_full) begin
        cur_word <= nxt_word;
        nxt_full <= 1'b0;
      end else if (load) begin
        cur_word <= word_data;
      end else begin
        cur_full <= 1'b0;
      end
    end else if (load) begin
      if (!cur_full) begin
        cur_word <= word_data;
        cur_full <= 1'b1;
      end else begin
        nxt_word <= word_data;
        nxt_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_unpacker.sv
// Unpacks fixed-width memory words into audio samples, one sample per sample_tick,
// with forward/reverse order, pause, underrun reporting and one-word prefetch.
module audio_unpacker
  import audio_pkg::*;
#(
  parameter int WORD_W   = AUDIO_WORD_W,
  parameter int SAMPLE_W = AUDIO_SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                play_audio,
  input  logic                forward,
  input  logic                word_valid,
  input  logic [WORD_W-1:0]   word_data,
  output logic                word_ready,
  output logic [SAMPLE_W-1:0] audio,
  output logic                audio_valid,
  output logic                underrun,
  output audio_state_e        dbg_state,
  output logic [WORD_W-1:0]   dbg_cur_word,
  output logic [WORD_W-1:0]   dbg_nxt_word
);

  localparam int NS    = WORD_W / SAMPLE_W;
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NS - 1);

  audio_state_e      state, state_next;
  logic [WORD_W-1:0] cur_word, nxt_word;
  logic              cur_full, nxt_empty;
  logic [IDX_W-1:0]  idx;
  logic              dir_fwd;
  logic              load, pop, cur_load, last_sample;
  logic              play_tick, empty_tick;

  // Handshake: a word transfers on any edge where word_valid && word_ready.
  // word_ready depends only on slot state and reset, never on word_valid.
  assign word_ready = reset & nxt_empty;
  assign load       = word_valid & word_ready;

  assign last_sample = dir_fwd ? (idx == IDX_LAST) : (idx == '0);
  assign pop         = play_tick & last_sample;
  // CUR takes a new word when free, or when exhausted and a replacement exists.
  assign cur_load    = (load & ~cur_full) | (pop & (~nxt_empty | load));

  audio_word_buf #(.WORD_W(WORD_W)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .pop       (pop),
    .word_data (word_data),
    .cur_word  (cur_word),
    .nxt_word  (nxt_word),
    .cur_full  (cur_full),
    .nxt_empty (nxt_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (load) state_next = PLAY;
      PLAY: begin
        if (pop && nxt_empty && !load) state_next = EMPTY;
        else if (!play_audio)          state_next = PAUSE;
      end
      PAUSE:   if (play_audio) state_next = PLAY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    play_tick  = (state == PLAY)  && sample_tick;
    empty_tick = (state == EMPTY) && sample_tick;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx         <= '0;
      dir_fwd     <= 1'b1;
      audio       <= '0;
      audio_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      audio_valid <= play_tick;
      underrun    <= empty_tick;
      if (play_tick) audio <= cur_word[SAMPLE_W * int'(idx) +: SAMPLE_W];
      // Direction is latched per word so mid-word changes wait for the next word.
      if (cur_load) begin
        dir_fwd <= forward;
        idx     <= forward ? '0 : IDX_LAST;
      end else if (play_tick) begin
        idx <= dir_fwd ? idx + 1'b1 : idx - 1'b1;
      end
    end
  end

  assign dbg_state    = state;
  assign dbg_cur_word = cur_word;
  assign dbg_nxt_word = nxt_word;

endmodule

// File: tb/tb_audio_unpacker.sv
// Directed bench for audio_unpacker: table of single-word vectors plus hand-written
// sequences for direction change, pause, underrun, back-to-back, reset and 16-bit samples.
module tb_audio_unpacker;
  import audio_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        sample_tick = 1'b0;
  logic        play_audio = 1'b1;
  logic        forward = 1'b1;
  logic        word_valid = 1'b0;
  logic        word_valid16 = 1'b0;
  logic [31:0] word_data = '0;

  logic         word_ready, audio_valid, underrun;
  logic [7:0]   audio;
  audio_state_e dbg_state;
  logic [31:0]  dbg_cur_word, dbg_nxt_word;

  logic         word_ready16, audio_valid16, underrun16;
  logic [15:0]  audio16;
  audio_state_e dbg_state16;
  logic [31:0]  dbg_cur_word16, dbg_nxt_word16;

  audio_unpacker dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .play_audio   (play_audio),
    .forward      (forward),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .audio        (audio),
    .audio_valid  (audio_valid),
    .underrun     (underrun),
    .dbg_state    (dbg_state),
    .dbg_cur_word (dbg_cur_word),
    .dbg_nxt_word (dbg_nxt_word)
  );

  audio_unpacker #(.WORD_W(32), .SAMPLE_W(16)) dut16 (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .play_audio   (play_audio),
    .forward      (forward),
    .word_valid   (word_valid16),
    .word_data    (word_data),
    .word_ready   (word_ready16),
    .audio        (audio16),
    .audio_valid  (audio_valid16),
    .underrun     (underrun16),
    .dbg_state    (dbg_state16),
    .dbg_cur_word (dbg_cur_word16),
    .dbg_nxt_word (dbg_nxt_word16)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b0;
    step();
    step();
    check({name, "_rst_audio"}, 32'(audio), 32'h0);
    check({name, "_rst_valid"}, 32'(audio_valid), 32'h0);
    check({name, "_rst_ready"}, 32'(word_ready), 32'h0);
    reset = 1'b1;
  endtask

  task automatic push(input int sel, input logic [31:0] w, input string name);
    logic rdy;
    bit   done;
    done = 1'b0;
    word_data = w;
    if (sel == 1) word_valid16 = 1'b1;
    else          word_valid   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #2;
      rdy = (sel == 1) ? word_ready16 : word_ready;
      step();
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    word_valid   = 1'b0;
    word_valid16 = 1'b0;
    if (!done) check({name, "_push_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic do_tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic tick_expect(input int sel, input logic [31:0] exp, input string name);
    do_tick();
    check({name, "_valid"}, (sel == 1) ? 32'(audio_valid16) : 32'(audio_valid), 32'h1);
    check({name, "_audio"}, (sel == 1) ? 32'(audio16) : 32'(audio), exp);
    step();
    check({name, "_pulse"}, (sel == 1) ? 32'(audio_valid16) : 32'(audio_valid), 32'h0);
  endtask

  typedef struct {
    logic        fwd;
    logic [31:0] word;
    logic [31:0] exp;   // expected samples in output order, first sample in bits [7:0]
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] words[2];
  int          widx, ticks, urun_cnt;
  logic        rdy;

  initial begin
    vecs[0] = '{fwd: 1'b1, word: 32'h12345678, exp: 32'h12345678};
    vecs[1] = '{fwd: 1'b0, word: 32'h12345678, exp: 32'h78563412};
    vecs[2] = '{fwd: 1'b1, word: 32'h0000A5C3, exp: 32'h0000A5C3};
    vecs[3] = '{fwd: 1'b0, word: 32'hDEADBEEF, exp: 32'hEFBEADDE};

    step();
    do_reset("init");
    check("init_underrun", 32'(underrun), 32'h0);
    check("init_state", 32'(dbg_state), 32'(EMPTY));

    // Table: one word, four ticks, four samples in the expected order.
    for (int v = 0; v < 4; v++) begin
      logic [31:0] e;
      do_reset($sformatf("vec%0d", v));
      forward = vecs[v].fwd;
      push(0, vecs[v].word, $sformatf("vec%0d", v));
      e = vecs[v].exp;
      for (int k = 0; k < 4; k++)
        tick_expect(0, 32'(e[8*k +: 8]), $sformatf("vec%0d_s%0d", v, k));
    end

    // Reverse word, direction flipped mid-word applies from the next word.
    do_reset("dir");
    forward = 1'b0;
    push(0, 32'h12345678, "dir_w0");
    push(0, 32'hAABBCCDD, "dir_w1");
    tick_expect(0, 32'h12, "dir_s0");
    forward = 1'b1;
    tick_expect(0, 32'h34, "dir_s1");
    tick_expect(0, 32'h56, "dir_s2");
    tick_expect(0, 32'h78, "dir_s3");
    tick_expect(0, 32'hDD, "dir_s4");
    tick_expect(0, 32'hCC, "dir_s5");
    tick_expect(0, 32'hBB, "dir_s6");
    tick_expect(0, 32'hAA, "dir_s7");

    // Pause after two samples: ticks ignored, audio held.
    do_reset("pause");
    push(0, 32'h12345678, "pause");
    tick_expect(0, 32'h78, "pause_s0");
    tick_expect(0, 32'h56, "pause_s1");
    play_audio = 1'b0;
    step();
    check("pause_state", 32'(dbg_state), 32'(PAUSE));
    for (int k = 0; k < 3; k++) begin
      do_tick();
      check("pause_valid", 32'(audio_valid), 32'h0);
      check("pause_urun", 32'(underrun), 32'h0);
      check("pause_hold", 32'(audio), 32'h56);
      step();
    end
    play_audio = 1'b1;
    step();
    tick_expect(0, 32'h34, "pause_s2");

    // Underrun on the fifth tick of a lone word.
    do_reset("urun");
    push(0, 32'h12345678, "urun");
    tick_expect(0, 32'h78, "urun_s0");
    tick_expect(0, 32'h56, "urun_s1");
    tick_expect(0, 32'h34, "urun_s2");
    tick_expect(0, 32'h12, "urun_s3");
    check("urun_state", 32'(dbg_state), 32'(EMPTY));
    do_tick();
    check("urun_pulse", 32'(underrun), 32'h1);
    check("urun_valid", 32'(audio_valid), 32'h0);
    check("urun_hold", 32'(audio), 32'h12);
    step();
    check("urun_clear", 32'(underrun), 32'h0);

    // Back-to-back words: eight samples, no gap, no underrun.
    do_reset("b2b");
    words[0] = 32'h12345678;
    words[1] = 32'hAABBCCDD;
    exp_q = {32'h78, 32'h56, 32'h34, 32'h12, 32'hDD, 32'hCC, 32'hBB, 32'hAA};
    widx = 0; ticks = 0; urun_cnt = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      word_valid  = (widx < 2);
      word_data   = words[(widx < 2) ? widx : 1];
      sample_tick = (cyc % 3 == 2) && (ticks < 8);
      #2;
      rdy = word_ready;
      step();
      if (word_valid && rdy) widx++;
      if (sample_tick) ticks++;
      if (audio_valid) begin
        if (exp_q.size() == 0) check("b2b_extra", 32'(audio), 32'hFFFF_FFFF);
        else                   check("b2b_sample", 32'(audio), exp_q.pop_front());
      end
      if (underrun) urun_cnt++;
    end
    word_valid = 1'b0;
    sample_tick = 1'b0;
    check("b2b_left", exp_q.size(), 32'h0);
    check("b2b_urun", urun_cnt, 32'h0);

    // Transfer on the same edge that exhausts CUR with NXT empty.
    do_reset("same");
    push(0, 32'h11223344, "same_w0");
    tick_expect(0, 32'h44, "same_s0");
    tick_expect(0, 32'h33, "same_s1");
    tick_expect(0, 32'h22, "same_s2");
    word_valid = 1'b1;
    word_data  = 32'h55667788;
    #2;
    check("same_ready", 32'(word_ready), 32'h1);
    do_tick();
    word_valid = 1'b0;
    check("same_s3", 32'(audio), 32'h11);
    check("same_state", 32'(dbg_state), 32'(PLAY));
    step();
    tick_expect(0, 32'h88, "same_s4");
    tick_expect(0, 32'h77, "same_s5");
    tick_expect(0, 32'h66, "same_s6");
    tick_expect(0, 32'h55, "same_s7");

    // Reset mid-word discards both slots.
    do_reset("rmw");
    push(0, 32'h12345678, "rmw_w0");
    push(0, 32'h9ABCDEF0, "rmw_w1");
    tick_expect(0, 32'h78, "rmw_s0");
    tick_expect(0, 32'h56, "rmw_s1");
    reset = 1'b0;
    word_valid = 1'b1;
    word_data  = 32'h0000A5C3;
    step();
    check("rmw_audio0", 32'(audio), 32'h0);
    check("rmw_ready0", 32'(word_ready), 32'h0);
    check("rmw_state", 32'(dbg_state), 32'(EMPTY));
    step();
    word_valid = 1'b0;
    reset = 1'b1;
    push(0, 32'h0000A5C3, "rmw_w2");
    tick_expect(0, 32'hC3, "rmw_s2");
    tick_expect(0, 32'hA5, "rmw_s3");
    tick_expect(0, 32'h00, "rmw_s4");
    tick_expect(0, 32'h00, "rmw_s5");

    // 16-bit samples.
    do_reset("w16");
    forward = 1'b1;
    push(1, 32'hBEEF1234, "w16_f");
    tick_expect(1, 32'h1234, "w16_f0");
    tick_expect(1, 32'hBEEF, "w16_f1");
    forward = 1'b0;
    push(1, 32'hBEEF1234, "w16_r");
    tick_expect(1, 32'hBEEF, "w16_r0");
    tick_expect(1, 32'h1234, "w16_r1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/audio_unpacker.md
AUDIO_UNPACKER -- requirements
Module: audio_unpacker

Interface
REQ-001 Parameter WORD_W, default 32: width of one memory word supplied by the flash reader.
REQ-002 Parameter SAMPLE_W, default 8: audio sample width. WORD_W SHALL be an integer multiple of SAMPLE_W. NS = WORD_W/SAMPLE_W samples per word.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 sample_tick  input  1  one-cycle strobe at the audio sample rate.
REQ-006 play_audio  input  1  1 = play, 0 = pause.
REQ-007 forward  input  1  1 = forward sample order, 0 = reverse.
REQ-008 word_valid  input  1  word_data holds a valid word.
REQ-009 word_data  input  WORD_W  packed samples.
REQ-010 word_ready  output  1  block accepts a word this cycle.
REQ-011 audio  output  SAMPLE_W  current sample, held between updates.
REQ-012 audio_valid  output  1  one-cycle pulse when audio updates.
REQ-013 underrun  output  1  one-cycle pulse when a tick finds no sample available.

Function
REQ-014 A word transfer SHALL occur on a cycle with word_valid=1 and word_ready=1.
REQ-015 The block SHALL hold two word slots: CUR (being played) and NXT (prefetch).
- word_ready SHALL be 1 whenever NXT is empty.
- word_ready SHALL be combinational from slot state only, not from word_valid.
REQ-016 FSM states SHALL be EMPTY, PLAY and PAUSE.
- EMPTY -> PLAY: on the first transfer; the word loads directly into CUR.
- PLAY -> PAUSE: when play_audio=0.
- PAUSE -> PLAY: when play_audio=1.
- PLAY -> EMPTY: when CUR is exhausted and NXT is empty.
REQ-017 Sample index SHALL start at the first sample of the word.
- Forward order: index 0 first, where index 0 is bits [SAMPLE_W-1:0].
- Reverse order: index NS-1 first.
- forward SHALL be sampled only when a word is loaded into CUR; changes mid-word take effect at the next word.
REQ-018 In PLAY, a sample_tick SHALL do all of the following on the next edge:
- drive audio with CUR[index];
- pulse audio_valid;
- advance the index (latency one cycle from tick).
REQ-019 When the last sample of CUR is output and NXT is full, NXT SHALL move into CUR on that same edge with the index restarted. The next tick plays the new word with no gap.
REQ-020 If a transfer and a CUR exhaustion occur on the same edge with NXT empty, the incoming word SHALL load directly into CUR and the state SHALL remain PLAY.
REQ-021 sample_tick in EMPTY SHALL pulse underrun, leave audio unchanged and not pulse audio_valid.
REQ-022 sample_tick in PAUSE SHALL be ignored: no index advance, no audio_valid, no underrun.
- Prefetch SHALL continue while paused.
REQ-023 audio SHALL hold its last value between updates, including through PAUSE and EMPTY.

Reset
REQ-024 When reset=0 at a rising edge, the block SHALL set:
- state EMPTY;
- CUR and NXT empty;
- audio = 0, audio_valid = 0, underrun = 0;
- index = 0.
REQ-025 Reset mid-word SHALL discard both slots.
- No transfer SHALL be accepted while reset=0 (word_ready = 0 during reset).
- The first sample after reset SHALL come from the first word transferred after reset.

Structure
REQ-026 Shared package audio_pkg SHALL hold:
- the FSM state enum (EMPTY, PLAY, PAUSE);
- default constants AUDIO_WORD_W=32 and AUDIO_SAMPLE_W=8.
REQ-027 The two-slot word buffer SHALL be a sub-module audio_word_buf.
- Parameter: WORD_W.
- Ports: load, pop, full/empty flags, CUR and NXT outputs.
- Sample selection and the FSM SHALL stay in audio_unpacker.

Verification
REQ-028 Forward basic: defaults, forward=1, word 32'h12345678, four ticks -> audio 78,56,34,12, each with one audio_valid pulse one cycle after its tick.
REQ-029 Reverse with direction change: forward=0 for word 32'h12345678, then forward toggled to 1 mid-word, second word 32'hAABBCCDD -> 12,34,56,78 then DD,CC,BB,AA.
REQ-030 Pause: play_audio=0 after second sample, three ticks, then play_audio=1 -> no audio_valid while paused, audio holds 56, next tick gives 34.
REQ-031 Underrun and back-to-back: single word, fifth tick -> underrun pulse, audio holds 12; words supplied on every word_ready -> eight consecutive samples with no underrun across the word boundary.
REQ-032 Reset mid-word: reset=0 after two samples, then new word 32'h0000A5C3 -> audio=0 during reset, next outputs C3,A5,00,00.
REQ-033 Parameter variant: WORD_W=32, SAMPLE_W=16, word 32'hBEEF1234, forward=1 -> 1234 then BEEF; same word with forward=0 -> BEEF then 1234.
